// File: rtl/msg_word_packer_pkg.sv
// Shared types and default sizing for the byte-to-word message packer.
package msg_word_packer_pkg;

    localparam int WORD_BYTES_DEF = 4;
    localparam int DEPTH_DEF      = 16;
    localparam int LEN_W_DEF      = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/msg_word_fifo.sv
// Synchronous word FIFO; head is shown combinationally from the read pointer.
module msg_word_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/msg_word_packer.sv
// Packs a byte stream MSB-first into words, tags the message tail and tracks message bit length.
module msg_word_packer
    import msg_word_packer_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [7:0]                      in_data,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic                            out_valid,
    output logic [8*WORD_BYTES-1:0]         out_data,
    output logic                            out_last,
    output logic [$clog2(WORD_BYTES+1)-1:0] out_nbytes,
    input  logic                            out_ready,
    output logic [LEN_W-1:0]                msg_bits,
    output logic                            msg_done,
    output logic [$clog2(DEPTH+1)-1:0]      level
);

    localparam int DW  = 8*WORD_BYTES;
    localparam int NBW = $clog2(WORD_BYTES+1);
    localparam int LVW = $clog2(DEPTH+1);
    localparam int FW  = DW + 1 + NBW;

    state_t         state_q, state_d;
    logic [NBW-1:0] fill_q;
    logic [DW-1:0]  acc_q;
    logic [DW-1:0]  word_d;
    logic           accept;
    logic           word_full;
    logic           push;
    logic           pop;
    logic [FW-1:0]  head;
    logic [DW-1:0]  head_data;
    logic           head_last;
    logic [NBW-1:0] head_nbytes;

    assign accept    = in_valid && in_ready;
    assign word_full = (fill_q == NBW'(WORD_BYTES-1));
    assign push      = accept && (word_full || in_last);
    assign pop       = out_valid && out_ready;

    // Drop the incoming byte into the lane selected by the current fill count.
    always_comb begin
        word_d = acc_q;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (fill_q == NBW'(b)) word_d[DW-1-8*b -: 8] = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else if (accept) begin
            if (push) begin
                acc_q  <= '0;
                fill_q <= '0;
            end else begin
                acc_q  <= word_d;
                fill_q <= fill_q + NBW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) state_d = in_last ? DONE : COLLECT;
    end

    // Any byte arriving outside COLLECT starts a fresh message count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_bits <= '0;
            msg_done <= 1'b0;
        end else begin
            msg_done <= accept && in_last;
            if (accept) begin
                if (state_q == COLLECT) msg_bits <= msg_bits + LEN_W'(8);
                else                    msg_bits <= LEN_W'(8);
            end
        end
    end

    msg_word_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_last, fill_q + NBW'(1), word_d}),
        .pop       (pop),
        .head      (head),
        .level     (level)
    );

    assign {head_last, head_nbytes, head_data} = head;

    // Mask the uninitialised storage so an empty FIFO presents all-zero outputs.
    assign in_ready   = (level != LVW'(DEPTH));
    assign out_valid  = (level != '0);
    assign out_data   = out_valid ? head_data   : '0;
    assign out_last   = out_valid ? head_last   : 1'b0;
    assign out_nbytes = out_valid ? head_nbytes : '0;

endmodule

// File: tb/tb_msg_word_packer.sv
// Directed scoreboard bench for msg_word_packer: default build plus WORD_BYTES=1/8, DEPTH=2 builds.
module tb_msg_word_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_last, in_ready, out_valid, out_last, out_ready, msg_done;
    logic [7:0]  in_data;
    logic [31:0] out_data;
    logic [2:0]  out_nbytes;
    logic [63:0] msg_bits;
    logic [4:0]  level;

    logic        s_valid, s_last, s_oready;
    logic [7:0]  s_data;
    logic        w1_ready, w1_valid, w1_last, w1_done;
    logic [7:0]  w1_data;
    logic [0:0]  w1_nb;
    logic [63:0] w1_bits;
    logic [1:0]  w1_level;
    logic        w8_ready, w8_valid, w8_last, w8_done;
    logic [63:0] w8_data;
    logic [3:0]  w8_nb;
    logic [63:0] w8_bits;
    logic [1:0]  w8_level;

    msg_word_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_nbytes(out_nbytes), .out_ready(out_ready), .msg_bits(msg_bits),
        .msg_done(msg_done), .level(level)
    );

    msg_word_packer #(.WORD_BYTES(1), .DEPTH(2)) dut_w1 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .in_last(s_last),
        .in_ready(w1_ready), .out_valid(w1_valid), .out_data(w1_data), .out_last(w1_last),
        .out_nbytes(w1_nb), .out_ready(s_oready), .msg_bits(w1_bits),
        .msg_done(w1_done), .level(w1_level)
    );

    msg_word_packer #(.WORD_BYTES(8), .DEPTH(2)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .in_last(s_last),
        .in_ready(w8_ready), .out_valid(w8_valid), .out_data(w8_data), .out_last(w8_last),
        .out_nbytes(w8_nb), .out_ready(s_oready), .msg_bits(w8_bits),
        .msg_done(w8_done), .level(w8_level)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [3:0]  nb;
    } exp_t;

    exp_t q_main[$];
    exp_t q_w1[$];
    exp_t q_w8[$];
    exp_t e_main, e_w1, e_w8;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic l, input logic [3:0] n);
        exp_t e;
        e.data = d;
        e.last = l;
        e.nb   = n;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_word", 64'(q_main.size()), 64'd1);
            end else begin
                e_main = q_main.pop_front();
                check("main_data",   64'(out_data),   e_main.data);
                check("main_last",   64'(out_last),   64'(e_main.last));
                check("main_nbytes", 64'(out_nbytes), 64'(e_main.nb));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && w1_valid && s_oready) begin
            if (q_w1.size() == 0) begin
                check("w1_unexpected_word", 64'(q_w1.size()), 64'd1);
            end else begin
                e_w1 = q_w1.pop_front();
                check("w1_data",   64'(w1_data), e_w1.data);
                check("w1_last",   64'(w1_last), 64'(e_w1.last));
                check("w1_nbytes", 64'(w1_nb),   64'(e_w1.nb));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && w8_valid && s_oready) begin
            if (q_w8.size() == 0) begin
                check("w8_unexpected_word", 64'(q_w8.size()), 64'd1);
            end else begin
                e_w8 = q_w8.pop_front();
                check("w8_data",   w8_data,       e_w8.data);
                check("w8_last",   64'(w8_last),  64'(e_w8.last));
                check("w8_nbytes", 64'(w8_nb),    64'(e_w8.nb));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("send_in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic s_send(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!(w1_ready && w8_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("sweep_in_ready", 64'(w1_ready && w8_ready), 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_main.size() + q_w1.size() + q_w8.size()) != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_remaining", 64'(q_main.size() + q_w1.size() + q_w8.size()), 64'd0);
    endtask

    initial begin
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
        s_valid  = 1'b0; s_data  = 8'h00; s_last  = 1'b0; s_oready  = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_level",      64'(level),      64'd0);
        check("rst_msg_bits",   msg_bits,        64'd0);
        check("rst_msg_done",   64'(msg_done),   64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_out_nbytes", 64'(out_nbytes), 64'd0);
        check("rst_out_last",   64'(out_last),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready",   64'(in_ready),   64'd1);

        // "abc": single partial word, latency and msg_done pulse
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        q_main.push_back(mk(64'h61626300, 1'b1, 4'd3));
        check("abc_latency_valid", 64'(out_valid), 64'd1);
        check("abc_msg_done",      64'(msg_done),  64'd1);
        check("abc_msg_bits",      msg_bits,       64'd24);
        @(posedge clk); #1;
        check("abc_msg_done_drop", 64'(msg_done),  64'd0);
        wait_drain();

        // 8 bytes -> two full words
        for (int i = 0; i < 8; i++) begin
            send(8'(i), i == 7);
            if (i == 3) q_main.push_back(mk(64'h00010203, 1'b0, 4'd4));
            if (i == 7) q_main.push_back(mk(64'h04050607, 1'b1, 4'd4));
        end
        check("eight_msg_bits", msg_bits, 64'd64);
        wait_drain();

        // Fill FIFO with out_ready low, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            send(8'(i), i == 63);
            if (i % 4 == 3)
                q_main.push_back(mk({32'd0, 8'(i-3), 8'(i-2), 8'(i-1), 8'(i)}, i == 63, 4'd4));
        end
        check("full_level",    64'(level),    64'd16);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_msg_bits", msg_bits,      64'd512);
        check("full_head",     64'(out_data), 64'h00010203);
        repeat (3) @(posedge clk);
        #1;
        check("full_head_hold",  64'(out_data),  64'h00010203);
        check("full_valid_hold", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_drain();
        check("full_drained_level", 64'(level), 64'd0);

        // Back-to-back one-byte messages
        send(8'hFF, 1'b1);
        q_main.push_back(mk(64'hFF000000, 1'b1, 4'd1));
        check("ff1_msg_done", 64'(msg_done), 64'd1);
        check("ff1_msg_bits", msg_bits,      64'd8);
        send(8'hFF, 1'b1);
        q_main.push_back(mk(64'hFF000000, 1'b1, 4'd1));
        check("ff2_msg_done", 64'(msg_done), 64'd1);
        check("ff2_msg_bits", msg_bits,      64'd8);
        wait_drain();

        // in_last without in_valid is ignored
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ign_msg_done", 64'(msg_done), 64'd0);
        in_last = 1'b0;
        send(8'h41, 1'b0);
        send(8'h42, 1'b1);
        q_main.push_back(mk(64'h41420000, 1'b1, 4'd2));
        check("ign_msg_bits", msg_bits, 64'd16);
        wait_drain();

        // Reset mid-message discards partial word and FIFO contents
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b0);
        check("mid_level_before", 64'(level), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_level",     64'(level),     64'd0);
        check("mid_rst_msg_bits",  msg_bits,       64'd0);
        check("mid_rst_out_data",  64'(out_data),  64'd0);
        q_main.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        q_main.push_back(mk(64'h61626300, 1'b1, 4'd3));
        wait_drain();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_level",    64'(level), 64'd0);
        check("post_rst_msg_bits", msg_bits,   64'd24);

        // Parameter sweep: WORD_BYTES=1 and 8 with DEPTH=2
        for (int i = 0; i < 10; i++) begin
            s_send(8'(i), i == 9);
            q_w1.push_back(mk(64'(i), i == 9, 4'd1));
            if (i == 7) q_w8.push_back(mk(64'h0001020304050607, 1'b0, 4'd8));
            if (i == 9) q_w8.push_back(mk(64'h0809000000000000, 1'b1, 4'd2));
        end
        check("w1_msg_bits", w1_bits, 64'd80);
        check("w8_msg_bits", w8_bits, 64'd80);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
